// File: rtl/score_display.sv
// Signed score to four active-low HEX digits (sign, hundreds, tens, units) via a one-bit-per-clock double-dabble.
// Latency 12 clocks, no backpressure: score is re-sampled in IDLE. Optional high-score tracking under `SCORE_HIGH_EN.
module score_display #(
  parameter int SCORE_W    = 10,
  parameter int BCD_DIGITS = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SCORE_W-1:0] score,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic               busy,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high
);

  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int BCD_W = 4 * BCD_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                     state, state_nxt;
  logic [SCORE_W-1:0]         last_score;
  logic [SCORE_W-1:0]         mag;
  logic                       neg;
  logic [BCD_W-1:0]           bcd;
  logic [BCD_W-1:0]           bcd_adj;
  logic [BCD_W+SCORE_W-1:0]   shifted;
  logic [CNT_W-1:0]           cnt;
  logic                       start;
  logic                       last_shift;
  logic [3:0]                 units, tens, hundreds;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign start      = (score != last_score);
  assign last_shift = (cnt == CNT_W'(SCORE_W - 1));
  assign units      = bcd[3:0];
  assign tens       = bcd[7:4];
  assign hundreds   = bcd[11:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction happens before every shift so each nibble stays a valid BCD digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, mag} << 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_score <= '0;
      mag        <= '0;
      neg        <= 1'b0;
      bcd        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      hex0       <= 7'b1000000;
      hex1       <= SEG_BLANK;
      hex2       <= SEG_BLANK;
      hex3       <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_score <= score;
            neg        <= score[SCORE_W-1];
            // -512 negates to itself; as unsigned that is the correct magnitude.
            mag        <= score[SCORE_W-1] ? -score : score;
            bcd        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          {bcd, mag} <= shifted;
          cnt        <= cnt + CNT_W'(1);
        end
        DONE: begin
          hex0 <= seg7(units);
          hex1 <= (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens);
          hex2 <= (hundreds == 4'd0) ? SEG_BLANK : seg7(hundreds);
          hex3 <= neg ? SEG_MINUS : SEG_BLANK;
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

`ifdef SCORE_HIGH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_score <= '0;
      new_high   <= 1'b0;
    end else begin
      new_high <= 1'b0;
      if (state == DONE && $signed(last_score) > $signed(high_score)) begin
        high_score <= last_score;
        new_high   <= 1'b1;
      end
    end
  end
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif

endmodule
